// File: rtl/miner_pkg.sv
// Shared constants and the controller state type for the nonce-sweep miner.
package miner_pkg;

    localparam int NONCE_W    = 32;
    localparam int HASH_W     = 256;
    localparam int MSG_W      = 1024;
    localparam int HDR_BASE_W = 608;

    // Bit length of an 80-byte message, appended as the SHA-256 length field.
    localparam logic [63:0] SHA_LEN_80B = 64'd640;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/miner_pad.sv
// Combinational SHA-256 padder for one 80-byte block header candidate.
module miner_pad #(
    parameter int NONCE_W = 32
) (
    input  logic [miner_pkg::HDR_BASE_W-1:0] header_base,
    input  logic [NONCE_W-1:0]               nonce,
    output logic [miner_pkg::MSG_W-1:0]      msg
);
    import miner_pkg::*;

    // Zero fill between the 0x80 marker bit and the 64-bit length field.
    localparam int ZERO_W = MSG_W - HDR_BASE_W - NONCE_W - 1 - 64;

    assign msg = {header_base, nonce, 1'b1, {ZERO_W{1'b0}}, SHA_LEN_80B};

endmodule

// File: rtl/miner_control.sv
// Nonce-sweep controller: issues padded candidates to the hash core and
// records the first returned hash that is at or below the target.
module miner_control #(
    parameter int NONCE_W      = 32,
    parameter int MAX_INFLIGHT = 4,
    parameter int HASH_W       = 256
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic                             abort,
    input  logic [miner_pkg::HDR_BASE_W-1:0] header_base,
    input  logic [NONCE_W-1:0]               nonce_start,
    input  logic [NONCE_W-1:0]               nonce_end,
    input  logic [HASH_W-1:0]                target,
    output logic                             core_req_valid,
    input  logic                             core_req_ready,
    output logic [miner_pkg::MSG_W-1:0]      core_req_msg,
    output logic [NONCE_W-1:0]               core_req_tag,
    input  logic                             core_resp_valid,
    input  logic [HASH_W-1:0]                core_resp_hash,
    input  logic [NONCE_W-1:0]               core_resp_tag,
    output logic                             busy,
    output logic                             done,
    output logic                             found,
    output logic [NONCE_W-1:0]               found_nonce,
    output logic [HASH_W-1:0]                found_hash,
    output logic [31:0]                      hashes_done
);
    import miner_pkg::*;

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    state_t                  state;
    state_t                  state_nxt;

    // One extra bit so a sweep ending at the all-ones nonce cannot wrap.
    logic [NONCE_W:0]        next_nonce;
    logic [CNT_W-1:0]        inflight;

    logic [HDR_BASE_W-1:0]   hdr_q;
    logic [NONCE_W-1:0]      nonce_end_q;
    logic [HASH_W-1:0]       target_q;
    logic [MSG_W-1:0]        pad_msg;

    logic                    accept_start;
    logic                    exhausted;
    logic                    req_fire;
    logic                    resp_take;
    logic                    resp_dec;
    logic                    hit;
    logic                    record_hit;

    assign accept_start   = (state == IDLE) && start;
    assign exhausted      = next_nonce > {1'b0, nonce_end_q};
    assign busy           = (state == RUN) || (state == DRAIN);

    // Requests stop the moment the FSM leaves RUN, which also withdraws a
    // stalled request on entry to DRAIN.
    assign core_req_valid = (state == RUN) && (inflight < CNT_W'(MAX_INFLIGHT)) && !exhausted;
    assign req_fire       = core_req_valid && core_req_ready;

    // Responses outside a sweep are stale and must not disturb any state.
    assign resp_take      = core_resp_valid && busy;
    assign resp_dec       = resp_take && (inflight != '0);
    assign hit            = resp_take && (core_resp_hash <= target_q);
    assign record_hit     = hit && !found;

    // Message and tag read as zero whenever no request is offered.
    assign core_req_msg   = core_req_valid ? pad_msg : '0;
    assign core_req_tag   = core_req_valid ? next_nonce[NONCE_W-1:0] : '0;

    miner_pad #(
        .NONCE_W(NONCE_W)
    ) u_pad (
        .header_base(hdr_q),
        .nonce      (next_nonce[NONCE_W-1:0]),
        .msg        (pad_msg)
    );

    // Sweep parameters are captured on an accepted start; they carry no reset.
    always_ff @(posedge clock) begin
        if (accept_start) begin
            hdr_q       <= header_base;
            nonce_end_q <= nonce_end;
            target_q    <= target;
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic for the sweep FSM.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (nonce_start <= nonce_end) ? RUN : DONE;
                end
            end
            RUN: begin
                if (abort || hit || exhausted) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Nonce counter, outstanding-request count and the one-cycle done pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            next_nonce <= '0;
            inflight   <= '0;
            done       <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (accept_start) begin
                next_nonce <= {1'b0, nonce_start};
            end else if (req_fire) begin
                next_nonce <= next_nonce + {{NONCE_W{1'b0}}, 1'b1};
            end
            unique case ({req_fire, resp_dec})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Response bookkeeping: count every response in a sweep, keep only the first hit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hashes_done <= '0;
            found       <= 1'b0;
            found_nonce <= '0;
            found_hash  <= '0;
        end else if (accept_start) begin
            hashes_done <= '0;
            found       <= 1'b0;
            found_nonce <= '0;
            found_hash  <= '0;
        end else begin
            if (resp_take) begin
                hashes_done <= hashes_done + 32'd1;
            end
            if (record_hit) begin
                found       <= 1'b1;
                found_nonce <= core_resp_tag;
                found_hash  <= core_resp_hash;
            end
        end
    end

endmodule

// File: tb/tb_miner_control.sv
// Self-checking bench for miner_control with a fixed-latency hash-core model.
module tb_miner_control;

    localparam int MI = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [607:0]  header_base = '0;
    logic [31:0]   nonce_start = '0;
    logic [31:0]   nonce_end = '0;
    logic [255:0]  target = '0;
    logic          core_req_valid;
    logic          core_req_ready = 1'b1;
    logic [1023:0] core_req_msg;
    logic [31:0]   core_req_tag;
    logic          core_resp_valid = 1'b0;
    logic [255:0]  core_resp_hash = '0;
    logic [31:0]   core_resp_tag = '0;
    logic          busy;
    logic          done;
    logic          found;
    logic [31:0]   found_nonce;
    logic [255:0]  found_hash;
    logic [31:0]   hashes_done;

    miner_control #(
        .NONCE_W(32),
        .MAX_INFLIGHT(MI),
        .HASH_W(256)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .header_base    (header_base),
        .nonce_start    (nonce_start),
        .nonce_end      (nonce_end),
        .target         (target),
        .core_req_valid (core_req_valid),
        .core_req_ready (core_req_ready),
        .core_req_msg   (core_req_msg),
        .core_req_tag   (core_req_tag),
        .core_resp_valid(core_resp_valid),
        .core_resp_hash (core_resp_hash),
        .core_resp_tag  (core_resp_tag),
        .busy           (busy),
        .done           (done),
        .found          (found),
        .found_nonce    (found_nonce),
        .found_hash     (found_hash),
        .hashes_done    (hashes_done)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Written only by the test sequence.
    logic [607:0] sweep_hdr = '0;
    int           stall_until = 0;
    logic         hit_en = 1'b0;
    logic [31:0]  hit_tag = '0;
    logic [255:0] hit_hash = '0;
    logic         hit2_en = 1'b0;
    logic [31:0]  hit2_tag = '0;
    int           ib = 0;

    // Written only by the core model.
    int           cyc = 0;
    logic [31:0]  pend_tag[$];
    int           pend_due[$];
    logic [31:0]  issued_q[$];
    int           out_cnt = 0;
    int           msg_bad = 0;
    int           stab_bad = 0;
    int           stab_seen = 0;
    int           over_cnt = 0;

    function automatic logic [1023:0] exp_msg(logic [607:0] h, logic [31:0] n);
        return {h, n, 1'b1, 319'b0, 64'd640};
    endfunction

    function automatic logic [255:0] miss_hash();
        logic [255:0] h;
        for (int i = 0; i < 8; i++) h[i*32 +: 32] = $urandom;
        h[255] = 1'b1;
        return h;
    endfunction

    function automatic logic [255:0] hash_for(logic [31:0] tag);
        if (hit_en && tag == hit_tag) return hit_hash;
        if (hit2_en && tag == hit2_tag) return '0;
        return miss_hash();
    endfunction

    // True when the sweep's issued tags are s, s+1, s+2, ... in order.
    function automatic bit in_order(int base, logic [31:0] s);
        for (int i = base; i < issued_q.size(); i++)
            if (issued_q[i] != s + 32'(i - base)) return 1'b0;
        return 1'b1;
    endfunction

    // Hash core: always ready unless stalled, fixed 3-cycle latency, in-order.
    initial begin : core_model
        logic          prev_stalled;
        logic [1023:0] prev_msg;
        logic [31:0]   prev_tag;
        logic [31:0]   t;
        int            d;
        prev_stalled = 1'b0;
        prev_msg = '0;
        prev_tag = '0;
        forever begin
            @(negedge clock);
            cyc++;
            if (pend_tag.size() > 0 && pend_due[0] <= cyc) begin
                t = pend_tag.pop_front();
                d = pend_due.pop_front();
                core_resp_valid = 1'b1;
                core_resp_tag   = t;
                core_resp_hash  = hash_for(t);
                out_cnt--;
            end else begin
                core_resp_valid = 1'b0;
            end
            core_req_ready = (cyc >= stall_until);
            if (core_req_valid && prev_stalled) begin
                stab_seen++;
                if (core_req_msg !== prev_msg || core_req_tag !== prev_tag) stab_bad++;
            end
            if (core_req_valid && core_req_ready) begin
                issued_q.push_back(core_req_tag);
                if (core_req_msg !== exp_msg(sweep_hdr, core_req_tag)) msg_bad++;
                pend_tag.push_back(core_req_tag);
                pend_due.push_back(cyc + 3);
                out_cnt++;
                if (out_cnt > MI) over_cnt++;
            end
            prev_stalled = core_req_valid && !core_req_ready;
            prev_msg     = core_req_msg;
            prev_tag     = core_req_tag;
        end
    end

    task automatic scramble_inputs();
        for (int i = 0; i < 19; i++) header_base[i*32 +: 32] = $urandom;
        nonce_start = $urandom;
        nonce_end   = $urandom;
        for (int i = 0; i < 8; i++) target[i*32 +: 32] = $urandom;
    endtask

    task automatic check_idle_outputs(input string tag);
        n_checks++;
        if (core_req_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || found !== 1'b0 ||
            found_nonce !== 32'd0 || found_hash !== 256'd0 || hashes_done !== 32'd0 ||
            core_req_msg !== 1024'd0 || core_req_tag !== 32'd0)
        begin
            n_fail++;
            $display("FAIL %s: valid=%0b busy=%0b done=%0b found=%0b nonce=%0h hashes=%0d msg_nz=%0b tag=%0h, required all zero",
                     tag, core_req_valid, busy, done, found, found_nonce, hashes_done,
                     core_req_msg != 0, core_req_tag);
        end
    endtask

    // Launch a sweep and wait for done; returns cycles from the start edge.
    task automatic run_sweep(input logic [31:0] s, input logic [31:0] e,
                             input logic [255:0] tgt, output int cycles);
        @(negedge clock);
        for (int i = 0; i < 19; i++) header_base[i*32 +: 32] = $urandom;
        sweep_hdr   = header_base;
        nonce_start = s;
        nonce_end   = e;
        target      = tgt;
        ib          = issued_q.size();
        start       = 1'b1;
        cycles      = 0;
        while (cycles < 3000) begin
            @(negedge clock);
            cycles++;
            if (cycles == 1) begin
                start = 1'b0;
                scramble_inputs();
            end
            if (cycles == 4) start = 1'b1;
            if (cycles == 5) start = 1'b0;
            if (done) break;
        end
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_timeout: done=%0b after %0d cycles, required 1", done, cycles);
        end
        n_checks++;
        if (out_cnt !== 0) begin
            n_fail++;
            $display("FAIL drained_at_done: outstanding=%0d, required 0", out_cnt);
        end
        @(negedge clock);
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: done=%0b one cycle later, required 0", done);
        end
    endtask

    task automatic check_model_flags(input string tag);
        n_checks++;
        if (msg_bad !== 0 || stab_bad !== 0 || over_cnt !== 0) begin
            n_fail++;
            $display("FAIL %s_core_side: msg_bad=%0d stab_bad=%0d over_inflight=%0d, required 0/0/0",
                     tag, msg_bad, stab_bad, over_cnt);
        end
    endtask

    task automatic check_counts(input string tag, input logic [31:0] s, input logic exp_found);
        int n;
        n = issued_q.size() - ib;
        n_checks++;
        if (!in_order(ib, s)) begin
            n_fail++;
            $display("FAIL %s_order: %0d tags issued not consecutive from %0h", tag, n, s);
        end
        n_checks++;
        if (hashes_done !== 32'(n)) begin
            n_fail++;
            $display("FAIL %s_hashes_done: got %0d, required %0d", tag, hashes_done, n);
        end
        n_checks++;
        if (found !== exp_found) begin
            n_fail++;
            $display("FAIL %s_found: got %0b, required %0b", tag, found, exp_found);
        end
    endtask

    task automatic test_reset();
        #1;
        check_idle_outputs("reset_state");
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check_idle_outputs("after_reset_release");
    endtask

    task automatic test_basic();
        int cyc_n;
        hit_en = 1'b0;
        hit2_en = 1'b0;
        run_sweep(32'd0, 32'd9, 256'd0, cyc_n);
        n_checks++;
        if (issued_q.size() - ib !== 10) begin
            n_fail++;
            $display("FAIL basic_count: issued %0d, required 10", issued_q.size() - ib);
        end
        check_counts("basic", 32'd0, 1'b0);
        check_model_flags("basic");
    endtask

    task automatic test_hit();
        int cyc_n;
        logic [31:0] s;
        logic [31:0] off;
        logic [31:0] tl;
        for (int it = 0; it < 3; it++) begin
            s   = (it == 0) ? 32'd0 : $urandom_range(0, 32'hFFFF0000);
            off = (it == 0) ? 32'd5 : $urandom_range(0, 20);
            tl  = (it == 0) ? 32'd1 : $urandom_range(2, 100000);
            hit_en   = 1'b1;
            hit_tag  = s + off;
            hit_hash = (it == 0) ? 256'd0 : 256'($urandom_range(1, tl));
            hit2_en  = (it != 0);
            hit2_tag = s + off + 32'd1;
            run_sweep(s, s + 32'd60, 256'(tl), cyc_n);
            check_counts("hit", s, 1'b1);
            n_checks++;
            if (found_nonce !== hit_tag || found_hash !== hit_hash) begin
                n_fail++;
                $display("FAIL hit_first: nonce=%0h hash=%0h, required nonce=%0h hash=%0h",
                         found_nonce, found_hash, hit_tag, hit_hash);
            end
            n_checks++;
            if (issued_q.size() == ib || issued_q[$] > hit_tag + 32'(MI)) begin
                n_fail++;
                $display("FAIL hit_stop: last issued %0h, required at most %0h",
                         (issued_q.size() == ib) ? 32'hx : issued_q[$], hit_tag + 32'(MI));
            end
        end
        hit_en = 1'b0;
        hit2_en = 1'b0;
        check_model_flags("hit");
    endtask

    task automatic test_wrap();
        int cyc_n;
        run_sweep(32'hFFFFFFFE, 32'hFFFFFFFF, 256'd0, cyc_n);
        n_checks++;
        if (issued_q.size() - ib !== 2) begin
            n_fail++;
            $display("FAIL wrap_count: issued %0d, required 2", issued_q.size() - ib);
        end
        check_counts("wrap", 32'hFFFFFFFE, 1'b0);
    endtask

    task automatic test_empty();
        int cyc_n;
        run_sweep(32'd10, 32'd3, 256'd0, cyc_n);
        n_checks++;
        if (cyc_n !== 2) begin
            n_fail++;
            $display("FAIL empty_latency: done after %0d cycles, required 2", cyc_n);
        end
        n_checks++;
        if (issued_q.size() - ib !== 0 || hashes_done !== 32'd0 || found !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_range: issued=%0d hashes=%0d found=%0b, required 0/0/0",
                     issued_q.size() - ib, hashes_done, found);
        end
    endtask

    task automatic test_stall_abort();
        int k;
        int seen0;
        @(negedge clock);
        for (int i = 0; i < 19; i++) header_base[i*32 +: 32] = $urandom;
        sweep_hdr   = header_base;
        nonce_start = 32'd0;
        nonce_end   = 32'd99;
        target      = 256'd0;
        ib          = issued_q.size();
        seen0       = stab_seen;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        k = 0;
        while (issued_q.size() - ib < 3 && k < 50) begin
            @(negedge clock);
            k++;
        end
        stall_until = cyc + 6;
        repeat (4) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        k = 0;
        while (!done && k < 500) begin
            @(negedge clock);
            k++;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_timeout: done=%0b, required 1", done);
        end
        n_checks++;
        if (out_cnt !== 0) begin
            n_fail++;
            $display("FAIL abort_drained: outstanding=%0d, required 0", out_cnt);
        end
        n_checks++;
        if (stab_seen - seen0 < 3) begin
            n_fail++;
            $display("FAIL stall_observed: %0d stalled cycles with valid, required >= 3",
                     stab_seen - seen0);
        end
        n_checks++;
        if (issued_q.size() - ib >= 100) begin
            n_fail++;
            $display("FAIL abort_early: issued %0d, required < 100", issued_q.size() - ib);
        end
        check_counts("abort", 32'd0, 1'b0);
        check_model_flags("stall");
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        int k;
        int cyc_n;
        @(negedge clock);
        for (int i = 0; i < 19; i++) header_base[i*32 +: 32] = $urandom;
        sweep_hdr   = header_base;
        nonce_start = 32'd0;
        nonce_end   = 32'd99;
        target      = 256'd0;
        ib          = issued_q.size();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        k = 0;
        while (out_cnt < 3 && k < 50) begin
            @(negedge clock);
            k++;
        end
        n_checks++;
        if (out_cnt !== 3) begin
            n_fail++;
            $display("FAIL reset_mid_setup: outstanding=%0d, required 3", out_cnt);
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_idle_outputs("reset_mid_sweep");
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (6) @(negedge clock);
        n_checks++;
        if (hashes_done !== 32'd0 || busy !== 1'b0 || out_cnt !== 0) begin
            n_fail++;
            $display("FAIL stale_ignored: hashes=%0d busy=%0b outstanding=%0d, required 0/0/0",
                     hashes_done, busy, out_cnt);
        end
        run_sweep(32'd20, 32'd29, 256'd0, cyc_n);
        n_checks++;
        if (issued_q.size() - ib !== 10) begin
            n_fail++;
            $display("FAIL post_reset_count: issued %0d, required 10", issued_q.size() - ib);
        end
        check_counts("post_reset", 32'd20, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hit();
        test_wrap();
        test_empty();
        test_stall_abort();
        test_reset_mid();
        check_model_flags("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/miner_control.md
Name: miner_control

Overview:
- Parametrised nonce-sweep controller for the Bitcoin miner datapath.
- Takes the 76-byte header prefix, a nonce range and a 256-bit target. It pads each 80-byte candidate into a 1024-bit SHA-256 message and issues candidates to a hash core over a valid/ready handshake, with up to MAX_INFLIGHT outstanding.
- Compares returned hashes against the target and reports the first hit.
- Sits between the host/UART command layer and the SHA256 core.

Parameters:
NONCE_W, 32, nonce width in bits.
MAX_INFLIGHT, 4, maximum outstanding requests to the core (1..16).
HASH_W, 256, hash and target width.

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a sweep (ignored while busy)
abort  in  1  one-cycle pulse; ends sweep early
header_base  in  608  header bytes 0..75 (version..bits), MSB = first byte
nonce_start  in  NONCE_W  first nonce, inclusive
nonce_end  in  NONCE_W  last nonce, inclusive
target  in  HASH_W  hit threshold
core_req_valid  out  1  request valid
core_req_ready  in  1  core accepts request
core_req_msg  out  1024  padded message
core_req_tag  out  NONCE_W  nonce of request
core_resp_valid  in  1  result valid (no backpressure)
core_resp_hash  in  HASH_W  result hash
core_resp_tag  in  NONCE_W  nonce of result
busy  out  1  high in RUN/DRAIN
done  out  1  one-cycle pulse at sweep end
found  out  1  hit recorded; held until next accepted start
found_nonce  out  NONCE_W  nonce of first hit
found_hash  out  HASH_W  hash of first hit
hashes_done  out  32  responses counted this sweep

Behaviour:
- Reset: all outputs 0; state IDLE; inflight=0; counters 0. Applies mid-sweep with no completion pulse.
- start, header_base, nonce_start, nonce_end and target are latched on an accepted start. Inputs may change afterwards.
- Message format: core_req_msg = {header_base, nonce, 1'b1, 319'b0, 64'd640}. This is standard SHA-256 padding for an 80-byte message. Byte-order conversion is outside this block.
- Next-nonce counter is NONCE_W+1 bits so nonce_end = all-ones does not wrap. Sweep exhausted when counter > nonce_end.
- States:
  - IDLE: on start, go to RUN if nonce_start <= nonce_end. Otherwise go to DONE (empty range: found=0, hashes_done=0).
  - RUN: core_req_valid = (inflight < MAX_INFLIGHT) && !exhausted. Asserted the cycle after start. The message is held stable while valid && !ready. On accept, nonce increments. Leave for DRAIN on exhausted, hit, or abort.
  - DRAIN: no new requests. A valid that is already asserted but not yet accepted is withdrawn on entry; this is legal because the request was not taken. Wait for inflight = 0.
  - DONE: done=1 for one cycle, then IDLE.
- Inflight: +1 on accept, −1 on response. Both in the same cycle leaves it unchanged. Never exceeds MAX_INFLIGHT.
- Every core_resp_valid in RUN/DRAIN increments hashes_done.
- Hit: core_resp_hash <= target, unsigned compare.
  - Only the first hit in response order is recorded into found, found_nonce and found_hash. Later hits are counted but ignored.
  - A hit in RUN moves to DRAIN the next cycle.
- Abort: in RUN, go to DRAIN. In DRAIN it is ignored. In IDLE it is ignored. Hits arriving during DRAIN after an abort are still recorded.
- Responses in IDLE/DONE are ignored and not counted.
- start while busy is ignored. start in the DONE cycle is ignored.

Decomposition:
- Package miner_pkg holds:
  - NONCE_W, HASH_W, MSG_W=1024, HDR_BASE_W=608, SHA_LEN_80B=64'd640.
  - State enum {IDLE, RUN, DRAIN, DONE}.
- Sub-module miner_pad: combinational padder that builds core_req_msg from header_base and nonce.

Test Plan:
- Model core with 3-cycle latency, always ready. nonce_start=0, nonce_end=9, target=0 → 10 requests, tags 0..9 in order; inflight never >4; found=0; hashes_done=10; one done pulse.
- Same, but the model returns hash=0 for tag 5, target=1 → found=1, found_nonce=5, found_hash=0. Issued nonces stop ≤ 5+MAX_INFLIGHT; done only after inflight=0.
- Range 0xFFFFFFFE..0xFFFFFFFF → exactly 2 requests, no wrap to 0, hashes_done=2.
- nonce_start=10, nonce_end=3 → no requests, done two cycles after start, found=0.
- core_req_ready low for 5 cycles mid-sweep → core_req_msg/tag stable while stalled. Then abort → done after outstanding responses return, found=0.
- Deassert reset_n while 3 requests are in flight → all outputs 0 immediately. A new start sweeps correctly, and stale responses before start are not counted.
